axis_rr_packet_arbiter: RTL and testbench

- Packet-level round-robin arbiter. It shares one AXI4-Stream datapath (typically the input of a width down-converter) between R upstream requesters.
- A grant is held from the first accepted beat until the beat carrying tlast is accepted, so packets are never interleaved.
- The arbiter adds no register stage on the data path; the downstream converter provides its own output slice.

---
 rtl/axis_rr_packet_arbiter_pkg.sv | 51 +++++
 rtl/axis_rr_packet_arbiter_if.sv | 29 ++
 rtl/axis_rr_packet_arbiter_pick.sv | 32 +++
 rtl/axis_rr_packet_arbiter.sv | 163 ++++++++++++++++
 tb/tb_axis_rr_packet_arbiter.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/axis_rr_packet_arbiter_pkg.sv
// Shared types and helpers for the AXI4-Stream round-robin packet arbiter.
//   axis_cfg_t   : stream shape (bytes per beat, TID/TDEST/TUSER widths, TSTRB/TKEEP usage)
//   arb_state_t  : one-hot arbiter state
//   sig_w/idx_w  : width helpers (zero-width fields collapse to 1 bit)
//   rr_pick      : behavioural round-robin pick, used as a reference by assertions
package axis_rr_packet_arbiter_pkg;

  localparam int MAX_R     = 16;
  localparam int MAX_IDX_W = 4;

  typedef struct packed {
    int bytes;
    int id_w;
    int dest_w;
    int user_w;
    bit use_tstrb;
    bit use_tkeep;
  } axis_cfg_t;

  localparam axis_cfg_t AXIS_CFG_DEFAULT = '{
    bytes: 4, id_w: 4, dest_w: 4, user_w: 1, use_tstrb: 1'b0, use_tkeep: 1'b1
  };

  typedef enum logic [1:0] {
    IDLE = 2'b01,
    BUSY = 2'b10
  } arb_state_t;

  function automatic int sig_w(int w);
    return (w > 0) ? w : 1;
  endfunction

  function automatic int idx_w(int r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

  // First requester found scanning upward from last+1 with wrap-around.
  function automatic logic [MAX_IDX_W-1:0] rr_pick(logic [MAX_R-1:0] req,
                                                   logic [MAX_IDX_W-1:0] last, int r);
    logic [MAX_IDX_W-1:0] pick;
    int k;
    pick = '0;
    // Walk from the farthest candidate back to last+1 so the nearest one wins.
    for (int s = r; s >= 1; s--) begin
      k = (int'(last) + s) % r;
      if (req[k]) pick = MAX_IDX_W'(k);
    end
    return pick;
  endfunction

endpackage

// File: rtl/axis_rr_packet_arbiter_if.sv
// AXI4-Stream bundle shaped by an axis_cfg_t.
//   master : drives tvalid/tdata/tstrb/tkeep/tid/tdest/tuser/tlast, receives tready
//   slave  : receives the payload, drives tready
interface axis_if
  import axis_rr_packet_arbiter_pkg::*;
#(
  parameter axis_cfg_t CONFIG = AXIS_CFG_DEFAULT
);
  localparam int DW  = 8 * sig_w(CONFIG.bytes);
  localparam int KW  = sig_w(CONFIG.bytes);
  localparam int IDW = sig_w(CONFIG.id_w);
  localparam int DSW = sig_w(CONFIG.dest_w);
  localparam int UW  = sig_w(CONFIG.user_w);

  logic           tvalid;
  logic           tready;
  logic [DW-1:0]  tdata;
  logic [KW-1:0]  tstrb;
  logic [KW-1:0]  tkeep;
  logic [IDW-1:0] tid;
  logic [DSW-1:0] tdest;
  logic [UW-1:0]  tuser;
  logic           tlast;

  modport master (output tvalid, tdata, tstrb, tkeep, tid, tdest, tuser, tlast,
                  input  tready);
  modport slave  (input  tvalid, tdata, tstrb, tkeep, tid, tdest, tuser, tlast,
                  output tready);
endinterface

// File: rtl/axis_rr_packet_arbiter_pick.sv
// Combinational round-robin picker: rotate the request vector so that
// last+1 lands at bit 0, priority-encode the lowest set bit, rotate back.
//   req  : request vector, one bit per port
//   last : most recently served port (lowest priority this round)
//   any  : at least one request present
//   idx  : chosen port, 0 when no request is present
module axis_rr_pick
  import axis_rr_packet_arbiter_pkg::*;
#(
  parameter int R = 2
) (
  input  logic [R-1:0]          req,
  input  logic [idx_w(R)-1:0]   last,
  output logic                  any,
  output logic [idx_w(R)-1:0]   idx
);
  localparam int IXW = idx_w(R);

  logic [R-1:0] rot;
  int           start;
  int           p;

  always_comb begin
    start = (int'(last) + 1) % R;
    rot   = '0;
    for (int j = 0; j < R; j++) rot[j] = req[(j + start) % R];
    p = 0;
    for (int j = R - 1; j >= 0; j--) if (rot[j]) p = j;
    any = |req;
    idx = any ? IXW'((start + p) % R) : '0;
  end
endmodule

// File: rtl/axis_rr_packet_arbiter.sv
// Packet-level round-robin arbiter sharing one AXI4-Stream between R requesters.
// A grant is held from the first accepted beat until tlast is accepted, so
// packets never interleave. No register stage on the data path.
//   aclk, aresetn : clock, asynchronous active-low reset
//   axis_in[R]    : requester streams (slave)
//   axis_out      : shared output stream (master)
//   grant_valid   : a packet is currently granted
//   grant_index   : granted port, holds its value between packets
//   watchdog_err  : one-cycle pulse after a packet is cut at MAX_BEATS beats
module axis_rr_packet_arbiter
  import axis_rr_packet_arbiter_pkg::*;
#(
  parameter axis_cfg_t CONFIG        = AXIS_CFG_DEFAULT,
  parameter int        R             = 2,
  parameter bit        TID_FROM_PORT = 1'b0,
  parameter int        MAX_BEATS     = 0
) (
  input  logic                aclk,
  input  logic                aresetn,
  axis_if.slave               axis_in [R],
  axis_if.master              axis_out,
  output logic                grant_valid,
  output logic [idx_w(R)-1:0] grant_index,
  output logic                watchdog_err
);
  localparam int IXW = idx_w(R);
  localparam int DW  = 8 * sig_w(CONFIG.bytes);
  localparam int KW  = sig_w(CONFIG.bytes);
  localparam int IDW = sig_w(CONFIG.id_w);
  localparam int DSW = sig_w(CONFIG.dest_w);
  localparam int UW  = sig_w(CONFIG.user_w);
  localparam int BW  = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;

  if (R < 2 || R > MAX_R) begin : g_bad_r
    $fatal(1, "axis_rr_packet_arbiter: R must be in 2..16");
  end

  arb_state_t     state;
  logic [IXW-1:0] g;
  logic [IXW-1:0] last_grant;
  logic [BW-1:0]  beat_cnt;

  logic [R-1:0]   in_tvalid;
  logic [R-1:0]   in_tlast;
  logic [R-1:0]   rdy_vec;
  logic [R-1:0]   grant_mask;
  logic [DW-1:0]  in_tdata [R];
  logic [KW-1:0]  in_tstrb [R];
  logic [KW-1:0]  in_tkeep [R];
  logic [IDW-1:0] in_tid   [R];
  logic [DSW-1:0] in_tdest [R];
  logic [UW-1:0]  in_tuser [R];

  logic           busy;
  logic           out_valid;
  logic           out_last;
  logic           xfer;
  logic           wd_hit;
  logic           pick_any;
  logic [IXW-1:0] pick_idx;
  logic [IDW-1:0] tid_mux;

  // busy is gated by aresetn so the handshake drops the moment reset asserts.
  assign busy = aresetn && (state == BUSY);

  for (genvar k = 0; k < R; k++) begin : g_port
    assign in_tvalid[k] = axis_in[k].tvalid;
    assign in_tlast[k]  = axis_in[k].tlast;
    assign in_tdata[k]  = axis_in[k].tdata;
    assign in_tstrb[k]  = axis_in[k].tstrb;
    assign in_tkeep[k]  = axis_in[k].tkeep;
    assign in_tid[k]    = axis_in[k].tid;
    assign in_tdest[k]  = axis_in[k].tdest;
    assign in_tuser[k]  = axis_in[k].tuser;
    assign rdy_vec[k]   = busy && (g == IXW'(k)) && axis_out.tready;
    assign axis_in[k].tready = rdy_vec[k];
  end

  axis_rr_pick #(.R(R)) u_pick (
    .req  (in_tvalid),
    .last (last_grant),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  // Watchdog cut: the MAX_BEATS-th beat of a packet is presented as its last.
  assign wd_hit    = (MAX_BEATS > 0) && (int'(beat_cnt) == MAX_BEATS - 1);
  assign out_valid = busy && in_tvalid[g];
  assign out_last  = in_tlast[g] || (busy && wd_hit);
  assign xfer      = out_valid && axis_out.tready;

  assign axis_out.tvalid = out_valid;
  assign axis_out.tlast  = out_last;
  assign axis_out.tdata  = in_tdata[g];
  assign axis_out.tstrb  = in_tstrb[g];
  assign axis_out.tkeep  = in_tkeep[g];
  assign axis_out.tdest  = in_tdest[g];
  assign axis_out.tuser  = in_tuser[g];
  assign tid_mux         = in_tid[g];

  if (TID_FROM_PORT) begin : g_tid_port
    if (CONFIG.id_w < IXW) begin : g_bad_tid
      $fatal(1, "axis_rr_packet_arbiter: TID too narrow to carry the port index");
    end else begin : g_tid_ok
      logic [IDW-1:0] tid_out;
      always_comb begin
        tid_out          = tid_mux;
        tid_out[IXW-1:0] = g;
      end
      assign axis_out.tid = tid_out;
    end
  end else begin : g_tid_pass
    assign axis_out.tid = tid_mux;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= IDLE;
      g            <= '0;
      last_grant   <= IXW'(R - 1);
      beat_cnt     <= '0;
      watchdog_err <= 1'b0;
    end else begin
      watchdog_err <= 1'b0;
      case (state)
        IDLE: begin
          beat_cnt <= '0;
          if (pick_any) begin
            g          <= pick_idx;
            last_grant <= pick_idx;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (xfer) begin
            if (out_last) begin
              state        <= IDLE;
              beat_cnt     <= '0;
              watchdog_err <= wd_hit && !in_tlast[g];
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign grant_valid = (state == BUSY);
  assign grant_index = g;
  assign grant_mask  = busy ? (R'(1) << g) : '0;

  a_ready_onehot: assert property (@(posedge aclk) disable iff (!aresetn)
    $onehot0(rdy_vec));
  a_ready_granted: assert property (@(posedge aclk) disable iff (!aresetn)
    (rdy_vec & ~grant_mask) == '0);
  a_hold_stall: assert property (@(posedge aclk) disable iff (!aresetn)
    (out_valid && !axis_out.tready) |=> (grant_valid && (out_valid == in_tvalid[g])));
  a_pick_ref: assert property (@(posedge aclk) disable iff (!aresetn)
    (state == IDLE && pick_any) |->
      (pick_idx == IXW'(rr_pick(MAX_R'(in_tvalid), MAX_IDX_W'(last_grant), R))));
endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
// Directed, table-driven bench for axis_rr_packet_arbiter (R=4, MAX_BEATS=8,
// TID_FROM_PORT=1) plus a few hand-written checks of the reset state and of
// the axis_rr_pick sub-module with a non power-of-two port count.
module tb_axis_rr_packet_arbiter;
  import axis_rr_packet_arbiter_pkg::*;

  localparam axis_cfg_t CFG = '{
    bytes: 1, id_w: 4, dest_w: 1, user_w: 1, use_tstrb: 1'b0, use_tkeep: 1'b1
  };

  typedef struct {
    logic       rst;
    logic [3:0] vld;
    logic [3:0] lst;
    logic       ordy;
    logic [3:0] b;
    logic       gv;
    logic [1:0] gi;
    logic       ov;
    logic [7:0] od;
    logic       ol;
    logic [3:0] rdy;
    logic       wd;
  } vec_t;

  logic       aclk = 1'b0;
  logic       aresetn;
  logic [3:0] vld;
  logic [3:0] lst;
  logic       ordy;
  logic [3:0] bnum;
  logic [3:0] rdy_obs;
  logic       gv;
  logic [1:0] gi;
  logic       wd;

  logic [2:0] preq;
  logic [1:0] plast;
  logic       pany;
  logic [1:0] pidx;

  int   n_chk  = 0;
  int   n_pass = 0;
  vec_t tv[$];

  always #5 aclk = ~aclk;

  axis_if #(.CONFIG(CFG)) in_if [4] ();
  axis_if #(.CONFIG(CFG)) out_if ();

  for (genvar k = 0; k < 4; k++) begin : g_src
    assign in_if[k].tvalid = vld[k];
    assign in_if[k].tlast  = lst[k];
    assign in_if[k].tdata  = {4'(k), bnum};
    assign in_if[k].tstrb  = 1'b1;
    assign in_if[k].tkeep  = 1'b1;
    assign in_if[k].tid    = 4'b1011;
    assign in_if[k].tdest  = 1'(k % 2);
    assign in_if[k].tuser  = 1'(k / 2);
    assign rdy_obs[k]      = in_if[k].tready;
  end
  assign out_if.tready = ordy;

  axis_rr_packet_arbiter #(
    .CONFIG(CFG), .R(4), .TID_FROM_PORT(1'b1), .MAX_BEATS(8)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .axis_in      (in_if),
    .axis_out     (out_if),
    .grant_valid  (gv),
    .grant_index  (gi),
    .watchdog_err (wd)
  );

  axis_rr_pick #(.R(3)) u_pick3 (
    .req  (preq),
    .last (plast),
    .any  (pany),
    .idx  (pidx)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h required %h", name, act, exp);
  endtask

  task automatic add(input logic rst, input logic [3:0] v, input logic [3:0] l,
                     input logic r, input logic [3:0] b, input logic egv,
                     input logic [1:0] egi, input logic eov, input logic [7:0] eod,
                     input logic eol, input logic [3:0] erdy, input logic ewd);
    vec_t e;
    e.rst = rst; e.vld = v; e.lst = l; e.ordy = r; e.b = b;
    e.gv = egv; e.gi = egi; e.ov = eov; e.od = eod; e.ol = eol; e.rdy = erdy; e.wd = ewd;
    tv.push_back(e);
  endtask

  task automatic pick_chk(input logic [2:0] rq, input logic [1:0] ls,
                          input logic eany, input logic [1:0] eidx);
    preq  = rq;
    plast = ls;
    #1;
    check($sformatf("pick req=%b last=%0d", rq, ls), {29'd0, pany, pidx}, {29'd0, eany, eidx});
  endtask

  initial begin
    vec_t e;
    logic [25:0] act;
    logic [25:0] exp;

    aresetn = 1'b0;
    vld = 4'b1111; lst = 4'b0000; ordy = 1'b1; bnum = 4'd0;
    preq = 3'b000; plast = 2'd0;

    // rst vld  lst  rdy b       gv gi ov od     ol rdy     wd
    // 1: port 0 alone, 4-beat packet
    add(0, 4'b0001, 4'b0000, 1, 4'd1, 0, 2'd0, 0, 8'h00, 0, 4'b0000, 0);
    add(0, 4'b0001, 4'b0000, 1, 4'd1, 1, 2'd0, 1, 8'h01, 0, 4'b0001, 0);
    add(0, 4'b0001, 4'b0000, 1, 4'd2, 1, 2'd0, 1, 8'h02, 0, 4'b0001, 0);
    add(0, 4'b0001, 4'b0000, 1, 4'd3, 1, 2'd0, 1, 8'h03, 0, 4'b0001, 0);
    add(0, 4'b0001, 4'b0001, 1, 4'd4, 1, 2'd0, 1, 8'h04, 1, 4'b0001, 0);
    add(0, 4'b0000, 4'b0000, 1, 4'd0, 0, 2'd0, 0, 8'h00, 0, 4'b0000, 0);
    // 2: all four ports, back-to-back 2-beat packets, order 0,1,2,3,0
    add(1, 4'b0000, 4'b0000, 1, 4'd0, 0, 2'd0, 0, 8'h00, 0, 4'b0000, 0);
    add(0, 4'b1111, 4'b0000, 1, 4'd1, 0, 2'd0, 0, 8'h00, 0, 4'b0000, 0);
    add(0, 4'b1111, 4'b0000, 1, 4'd1, 1, 2'd0, 1, 8'h01, 0, 4'b0001, 0);
    add(0, 4'b1111, 4'b1111, 1, 4'd2, 1, 2'd0, 1, 8'h02, 1, 4'b0001, 0);
    add(0, 4'b1111, 4'b0000, 1, 4'd1, 0, 2'd0, 0, 8'h00, 0, 4'b0000, 0);
    add(0, 4'b1111, 4'b0000, 1, 4'd1, 1, 2'd1, 1, 8'h11, 0, 4'b0010, 0);
    add(0, 4'b1111, 4'b1111, 1, 4'd2, 1, 2'd1, 1, 8'h12, 1, 4'b0010, 0);
    add(0, 4'b1111, 4'b0000, 1, 4'd1, 0, 2'd1, 0, 8'h00, 0, 4'b0000, 0);
    add(0, 4'b1111, 4'b0000, 1, 4'd1, 1, 2'd2, 1, 8'h21, 0, 4'b0100, 0);
    add(0, 4'b1111, 4'b1111, 1, 4'd2, 1, 2'd2, 1, 8'h22, 1, 4'b0100, 0);
    add(0, 4'b1111, 4'b0000, 1, 4'd1, 0, 2'd2, 0, 8'h00, 0, 4'b0000, 0);
    add(0, 4'b1111, 4'b0000, 1, 4'd1, 1, 2'd3, 1, 8'h31, 0, 4'b1000, 0);
    add(0, 4'b1111, 4'b1111, 1, 4'd2, 1, 2'd3, 1, 8'h32, 1, 4'b1000, 0);
    add(0, 4'b1111, 4'b0000, 1, 4'd1, 0, 2'd3, 0, 8'h00, 0, 4'b0000, 0);
    add(0, 4'b1111, 4'b0000, 1, 4'd1, 1, 2'd0, 1, 8'h01, 0, 4'b0001, 0);
    add(0, 4'b1111, 4'b1111, 1, 4'd2, 1, 2'd0, 1, 8'h02, 1, 4'b0001, 0);
    add(0, 4'b0000, 4'b0000, 1, 4'd0, 0, 2'd0, 0, 8'h00, 0, 4'b0000, 0);
    // 3: port 1 granted, drops tvalid for 3 cycles while port 2 waits
    add(0, 4'b0110, 4'b0000, 1, 4'd1, 0, 2'd0, 0, 8'h00, 0, 4'b0000, 0);
    add(0, 4'b0110, 4'b0000, 1, 4'd1, 1, 2'd1, 1, 8'h11, 0, 4'b0010, 0);
    add(0, 4'b0100, 4'b0000, 1, 4'd2, 1, 2'd1, 0, 8'h00, 0, 4'b0010, 0);
    add(0, 4'b0100, 4'b0000, 1, 4'd2, 1, 2'd1, 0, 8'h00, 0, 4'b0010, 0);
    add(0, 4'b0100, 4'b0000, 1, 4'd2, 1, 2'd1, 0, 8'h00, 0, 4'b0010, 0);
    add(0, 4'b0110, 4'b0010, 1, 4'd2, 1, 2'd1, 1, 8'h12, 1, 4'b0010, 0);
    add(0, 4'b0100, 4'b0100, 1, 4'd1, 0, 2'd1, 0, 8'h00, 0, 4'b0000, 0);
    add(0, 4'b0100, 4'b0100, 1, 4'd1, 1, 2'd2, 1, 8'h21, 1, 4'b0100, 0);
    add(0, 4'b0000, 4'b0000, 1, 4'd0, 0, 2'd2, 0, 8'h00, 0, 4'b0000, 0);
    // 4: sink tready 1,0,0,1 in the middle of a port 0 packet
    add(0, 4'b0001, 4'b0000, 1, 4'd1, 0, 2'd2, 0, 8'h00, 0, 4'b0000, 0);
    add(0, 4'b0001, 4'b0000, 1, 4'd1, 1, 2'd0, 1, 8'h01, 0, 4'b0001, 0);
    add(0, 4'b0001, 4'b0000, 1, 4'd2, 1, 2'd0, 1, 8'h02, 0, 4'b0001, 0);
    add(0, 4'b0001, 4'b0000, 0, 4'd3, 1, 2'd0, 1, 8'h03, 0, 4'b0000, 0);
    add(0, 4'b0001, 4'b0000, 0, 4'd3, 1, 2'd0, 1, 8'h03, 0, 4'b0000, 0);
    add(0, 4'b0001, 4'b0001, 1, 4'd3, 1, 2'd0, 1, 8'h03, 1, 4'b0001, 0);
    add(0, 4'b0000, 4'b0000, 1, 4'd0, 0, 2'd0, 0, 8'h00, 0, 4'b0000, 0);
    // 5: port 3 sends 12 beats, watchdog cuts after beat 8
    add(0, 4'b1000, 4'b0000, 1, 4'd1, 0, 2'd0, 0, 8'h00, 0, 4'b0000, 0);
    for (int b = 1; b <= 8; b++)
      add(0, 4'b1000, 4'b0000, 1, 4'(b), 1, 2'd3, 1, {4'h3, 4'(b)}, (b == 8), 4'b1000, 0);
    add(0, 4'b1000, 4'b0000, 1, 4'd9, 0, 2'd3, 0, 8'h00, 0, 4'b0000, 1);
    for (int b = 9; b <= 12; b++)
      add(0, 4'b1000, (b == 12) ? 4'b1000 : 4'b0000, 1, 4'(b), 1, 2'd3, 1, {4'h3, 4'(b)},
          (b == 12), 4'b1000, 0);
    add(0, 4'b0000, 4'b0000, 1, 4'd0, 0, 2'd3, 0, 8'h00, 0, 4'b0000, 0);
    // 6: reset in the middle of a port 2 packet, then port 0 wins again
    add(0, 4'b0100, 4'b0000, 1, 4'd1, 0, 2'd3, 0, 8'h00, 0, 4'b0000, 0);
    add(0, 4'b0100, 4'b0000, 1, 4'd1, 1, 2'd2, 1, 8'h21, 0, 4'b0100, 0);
    add(1, 4'b0100, 4'b0000, 1, 4'd2, 0, 2'd0, 0, 8'h00, 0, 4'b0000, 0);
    add(0, 4'b0000, 4'b0000, 1, 4'd0, 0, 2'd0, 0, 8'h00, 0, 4'b0000, 0);
    add(0, 4'b0000, 4'b0000, 1, 4'd0, 0, 2'd0, 0, 8'h00, 0, 4'b0000, 0);
    add(0, 4'b1111, 4'b0000, 1, 4'd1, 0, 2'd0, 0, 8'h00, 0, 4'b0000, 0);
    add(0, 4'b1111, 4'b1111, 1, 4'd1, 1, 2'd0, 1, 8'h01, 1, 4'b0001, 0);
    add(0, 4'b0000, 4'b0000, 1, 4'd0, 0, 2'd0, 0, 8'h00, 0, 4'b0000, 0);

    // Reset held with every port requesting: all outputs must stay low.
    repeat (2) @(negedge aclk);
    #1;
    check("reset grant_valid", {31'd0, gv}, 32'd0);
    check("reset grant_index", {30'd0, gi}, 32'd0);
    check("reset out tvalid", {31'd0, out_if.tvalid}, 32'd0);
    check("reset in tready", {28'd0, rdy_obs}, 32'd0);
    check("reset watchdog_err", {31'd0, wd}, 32'd0);

    for (int r = 0; r < tv.size(); r++) begin
      @(negedge aclk);
      e       = tv[r];
      aresetn = ~e.rst;
      vld     = e.vld;
      lst     = e.lst;
      ordy    = e.ordy;
      bnum    = e.b;
      #1;
      exp = {e.gv, e.gi, e.ov,
             (e.ov ? {e.od, e.ol, 2'b10, e.gi, 2'b11, e.gi[0], e.gi[1]} : 17'd0),
             e.rdy, e.wd};
      act = {gv, gi, out_if.tvalid,
             (e.ov ? {out_if.tdata, out_if.tlast, out_if.tid, out_if.tstrb, out_if.tkeep,
                      out_if.tdest, out_if.tuser} : 17'd0),
             rdy_obs, wd};
      check($sformatf("row%0d", r), 32'(act), 32'(exp));
    end

    // Stand-alone picker with three ports.
    pick_chk(3'b101, 2'd0, 1'b1, 2'd2);
    pick_chk(3'b101, 2'd2, 1'b1, 2'd0);
    pick_chk(3'b010, 2'd1, 1'b1, 2'd1);
    pick_chk(3'b110, 2'd2, 1'b1, 2'd1);
    pick_chk(3'b011, 2'd0, 1'b1, 2'd1);
    pick_chk(3'b000, 2'd1, 1'b0, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
